pwm_output_stage: RTL
=====================

// Module: pwm_output_stage
// PURPOSE
//   Consumes the five control registers written over SPI (output enables, PWM enables, duty cycle).
//   Drives the 16 chip outputs as constant-low, constant-high or PWM.
//   Contains a clock prescaler, an 8-bit PWM period counter and a duty shadow register.
//   The duty shadow is reloaded only at period boundaries, so a duty write never produces a runt pulse.
// PARAMETERS
//   PRESCALE   13   clk cycles per PWM count step; legal range 1..255 (13 at 10 MHz gives ~3.0 kHz)
// PORTS
//   clk              in   1   system clock; all logic on rising edge
//   rst_n            in   1   synchronous reset, active low
//   en_reg_out_7_0   in   8   output enable, out[7:0]
//   en_reg_out_15_8  in   8   output enable, out[15:8]
//   en_reg_pwm_7_0   in   8   PWM select, out[7:0]
//   en_reg_pwm_15_8  in   8   PWM select, out[15:8]
//   pwm_duty_cycle   in   8   requested duty; high for duty/256 of a period, 0xFF = 100%
//   out              out  16  registered output pins
//   period_start     out  1   one-cycle pulse in the first clk of each PWM period
// BEHAVIOUR
//   Reset (rst_n=0 at a clk edge):
//   - pre_cnt=0, pwm_cnt=0, duty_sh=0, out=16'h0000, period_start=0.
//   - Takes effect mid-period at the next edge; no state survives it.
//   Prescaler:
//   - pre_cnt counts 0..PRESCALE-1 and wraps to 0.
//   - tick=1 while pre_cnt==PRESCALE-1.
//   - PRESCALE=1: tick is high every cycle.
//   Period counter:
//   - pwm_cnt (8b) increments on tick; wraps 255->0.
//   - One period = 256*PRESCALE clk cycles.
//   - wrap = tick && pwm_cnt==255.
//   Duty shadow:
//   - On wrap, duty_sh <= pwm_duty_cycle; no update at any other time.
//   - Latency from a duty write to effect: up to one full period.
//   - Duty sampled in the wrap cycle is the one used, including a change in that same cycle.
//   period_start:
//   - Registered copy of wrap, so it is high in the first cycle with pwm_cnt==0.
//   - Stays 0 until the first wrap after reset.
//   PWM level (combinational):
//   - lvl = (duty_sh==8'hFF) ? 1 : (pwm_cnt < duty_sh).
//   - duty_sh==0: lvl always 0.
//   - duty_sh==N, 0<N<255: high for pwm_cnt 0..N-1, i.e. N*PRESCALE cycles per period.
//   Output mux, per bit i, registered with 1 clk latency:
//   - out[i] <= en_out[i] ? (en_pwm[i] ? lvl : 1) : 0,
//     where en_out={en_reg_out_15_8,en_reg_out_7_0} and en_pwm likewise.
//   - Enable and PWM-select changes are not shadowed; they appear on out one cycle after the input changes.
//   - en_out=0 forces 0 regardless of en_pwm.
//   - All PWM-selected bits share lvl and switch in the same cycle.
//   No handshake: inputs are level-held registers and are sampled every cycle.
// TESTING
//   1 Reset: rst_n=0 for 2 cycles with all enables 0xFF and duty 0x80 -> out=0000, period_start=0; counters at 0.
//   2 Static: en_out=FFFF, en_pwm=0000 -> out=FFFF one cycle later; en_out=00FF -> out=00FF.
//   3 PWM 50%: PRESCALE=13, en_out=en_pwm=0001, duty=0x80 -> after the first period_start, out[0] is high 1664 cycles then low 1664; period_start every 3328 cycles.
//   4 Extremes: duty=0x00 -> out[0] low across a full period; duty=0xFF -> out[0] high across a full period with no low cycle at the wrap.
//   5 Glitch-free update: duty 0x40->0xC0 at pwm_cnt=0x80 -> current period keeps 0x40 timing; next period_start begins 0xC0 timing (high 2496 cycles).
//   6 Reset mid-period: assert rst_n=0 at pwm_cnt=0x55 -> next cycle out=0 and counters 0; after release, the first period is low until a wrap loads duty.

Source files
------------

// File: rtl/pwm_output_stage.sv
// PWM output stage: prescaled 8-bit period counter with a duty shadow that reloads
// only at period wrap, driving 16 registered pins as low, high or PWM.
module pwm_output_stage #(
  parameter int unsigned PRESCALE = 13
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_start
);

  localparam logic [7:0] PRE_LAST = 8'(PRESCALE - 1);

  logic [7:0]  pre_cnt;
  logic [7:0]  pwm_cnt;
  logic [7:0]  duty_sh;
  logic        tick;
  logic        wrap;
  logic        lvl;
  logic [15:0] en_out;
  logic [15:0] en_pwm;
  logic [15:0] out_nxt;

  assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  assign tick = (pre_cnt == PRE_LAST);
  assign wrap = tick && (pwm_cnt == 8'hFF);

  // 0xFF is treated as 100% so the pin never drops for the pwm_cnt==255 slot
  always_comb begin
    lvl = 1'b0;
    if (duty_sh == 8'hFF) lvl = 1'b1;
    else                  lvl = (pwm_cnt < duty_sh);
  end

  always_comb begin
    out_nxt = en_out & (~en_pwm | {16{lvl}});
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_cnt      <= '0;
      pwm_cnt      <= '0;
      duty_sh      <= '0;
      out          <= '0;
      period_start <= 1'b0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + 8'd1;
      if (tick) pwm_cnt <= pwm_cnt + 8'd1;
      if (wrap) duty_sh <= pwm_duty_cycle;
      period_start <= wrap;
      out          <= out_nxt;
    end
  end

endmodule
